// File: rtl/gmii_tx_framer_if.sv
// Upstream byte stream plus GMII transmit side of the frame serialiser.
// The framer uses the slave view and the byte source uses the master view.
interface gmii_tx_framer_if;
    logic [7:0] iv_data;
    logic       i_valid;
    logic       i_sop;
    logic       i_eop;
    logic       o_ready;
    logic       o_gmii_tx_en;
    logic       o_gmii_tx_er;
    logic [7:0] ov_gmii_txd;
    logic       o_underrun;

    modport slave (
        input  iv_data, i_valid, i_sop, i_eop,
        output o_ready, o_gmii_tx_en, o_gmii_tx_er, ov_gmii_txd, o_underrun
    );

    modport master (
        output iv_data, i_valid, i_sop, i_eop,
        input  o_ready, o_gmii_tx_en, o_gmii_tx_er, ov_gmii_txd, o_underrun
    );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: adds preamble/SFD, pads short frames, appends CRC-32 FCS,
// aborts on upstream underrun and enforces the inter-frame gap.
module gmii_tx_framer #(
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned MIN_FRAME  = 60
) (
    input  logic           i_clk,
    input  logic           i_rst,
    gmii_tx_framer_if.slave bus
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG, DROP} state_t;

    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    state_t      state, state_nx;
    logic [10:0] byte_cnt, byte_cnt_nx, cnt_inc;
    logic [15:0] step, step_nx;
    logic [31:0] crc, crc_nx;
    logic        tx_en_nx, tx_er_nx, underrun_nx, ready;
    logic [7:0]  txd_nx;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign cnt_inc     = (byte_cnt == '1) ? byte_cnt : byte_cnt + 11'd1;
    assign bus.o_ready = ready & ~i_rst;

    // The first preamble byte is launched from IDLE so the wire gap equals IFG_CYCLES.
    always_comb begin
        state_nx    = state;
        byte_cnt_nx = byte_cnt;
        step_nx     = step;
        crc_nx      = crc;
        tx_en_nx    = 1'b0;
        tx_er_nx    = 1'b0;
        txd_nx      = '0;
        underrun_nx = 1'b0;
        ready       = 1'b0;
        case (state)
            IDLE: begin
                byte_cnt_nx = '0;
                crc_nx      = '1;
                step_nx     = '0;
                if (bus.i_valid) begin
                    if (bus.i_sop) begin
                        state_nx = PREAMBLE;
                        tx_en_nx = 1'b1;
                        txd_nx   = 8'h55;
                    end else begin
                        ready = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                tx_en_nx = 1'b1;
                txd_nx   = 8'h55;
                if (step == 16'd5) begin
                    step_nx  = '0;
                    state_nx = SFD;
                end else begin
                    step_nx = step + 16'd1;
                end
            end
            SFD: begin
                tx_en_nx    = 1'b1;
                txd_nx      = 8'hD5;
                byte_cnt_nx = '0;
                crc_nx      = '1;
                state_nx    = DATA;
            end
            DATA: begin
                ready    = 1'b1;
                tx_en_nx = 1'b1;
                if (bus.i_valid) begin
                    txd_nx      = bus.iv_data;
                    crc_nx      = crc_byte(crc, bus.iv_data);
                    byte_cnt_nx = cnt_inc;
                    if (bus.i_eop)
                        state_nx = (cnt_inc < MIN_CNT) ? PAD : FCS;
                end else begin
                    tx_er_nx    = 1'b1;
                    underrun_nx = 1'b1;
                    state_nx    = DROP;
                end
            end
            PAD: begin
                tx_en_nx    = 1'b1;
                crc_nx      = crc_byte(crc, 8'h00);
                byte_cnt_nx = cnt_inc;
                if (cnt_inc >= MIN_CNT)
                    state_nx = FCS;
            end
            FCS: begin
                tx_en_nx = 1'b1;
                case (step[1:0])
                    2'd0:    txd_nx = ~crc[7:0];
                    2'd1:    txd_nx = ~crc[15:8];
                    2'd2:    txd_nx = ~crc[23:16];
                    default: txd_nx = ~crc[31:24];
                endcase
                if (step[1:0] == 2'd3) begin
                    step_nx  = '0;
                    state_nx = IFG;
                end else begin
                    step_nx = step + 16'd1;
                end
            end
            IFG: begin
                if (step == IFG_LAST) begin
                    step_nx  = '0;
                    state_nx = IDLE;
                end else begin
                    step_nx = step + 16'd1;
                end
            end
            DROP: begin
                ready = 1'b1;
                if (bus.i_valid && bus.i_eop) begin
                    step_nx  = '0;
                    state_nx = IFG;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= IDLE;
            byte_cnt         <= '0;
            step             <= '0;
            crc              <= '1;
            bus.o_gmii_tx_en <= 1'b0;
            bus.o_gmii_tx_er <= 1'b0;
            bus.ov_gmii_txd  <= '0;
            bus.o_underrun   <= 1'b0;
        end else begin
            state            <= state_nx;
            byte_cnt         <= byte_cnt_nx;
            step             <= step_nx;
            crc              <= crc_nx;
            bus.o_gmii_tx_en <= tx_en_nx;
            bus.o_gmii_tx_er <= tx_er_nx;
            bus.ov_gmii_txd  <= txd_nx;
            bus.o_underrun   <= underrun_nx;
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer: random frames against a queue-based
// model of the expected wire image (preamble, SFD, padded body, table-driven FCS).
module tb_gmii_tx_framer;

    localparam int unsigned IFG  = 12;
    localparam int unsigned MINF = 60;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gmii_tx_framer_if bus();

    gmii_tx_framer #(.IFG_CYCLES(IFG), .MIN_FRAME(MINF)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  cap[$];
    int          frame_end[$];
    int          gaps[$];
    int          er_cnt, un_cnt, rdy_cnt, low_run;
    logic        prev_en;
    bit          seen_fall;
    logic [31:0] crc_tab[256];

    always @(negedge clk) begin
        if (bus.o_gmii_tx_en) begin
            cap.push_back(bus.ov_gmii_txd);
            if (!prev_en && seen_fall) gaps.push_back(low_run);
        end else begin
            if (prev_en) begin
                frame_end.push_back(cap.size());
                seen_fall = 1'b1;
                low_run   = 1;
            end else begin
                low_run++;
            end
        end
        if (bus.o_gmii_tx_er) er_cnt++;
        if (bus.o_underrun)   un_cnt++;
        if (bus.o_ready)      rdy_cnt++;
        prev_en = bus.o_gmii_tx_en;
    end

    task automatic clear_mon();
        @(posedge clk); #1;
        cap = {}; frame_end = {}; gaps = {};
        er_cnt = 0; un_cnt = 0; rdy_cnt = 0; low_run = 0;
        seen_fall = 1'b0;
    endtask

    function automatic logic [31:0] fcs_of(input bq_t d);
        logic [31:0] c;
        c = '1;
        foreach (d[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ d[i]];
        return ~c;
    endfunction

    function automatic bq_t build_expected(input bq_t d);
        bq_t e, body;
        logic [31:0] f;
        e = {};
        for (int i = 0; i < 7; i++) e.push_back(8'h55);
        e.push_back(8'hD5);
        body = d;
        while (body.size() < MINF) body.push_back(8'h00);
        f = fcs_of(body);
        foreach (body[i]) e.push_back(body[i]);
        for (int k = 0; k < 4; k++) e.push_back(f[8*k +: 8]);
        return e;
    endfunction

    function automatic bq_t frame_bytes(input int k);
        bq_t r;
        int s;
        r = {};
        if (k >= frame_end.size()) return r;
        s = (k == 0) ? 0 : frame_end[k-1];
        for (int i = s; i < frame_end[k]; i++) r.push_back(cap[i]);
        return r;
    endfunction

    function automatic int count_diff(input bq_t a, input bq_t b);
        int n;
        n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) n++;
        return n;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t r;
        r = {};
        for (int i = 0; i < n; i++) r.push_back(8'($urandom_range(0, 255)));
        return r;
    endfunction

    task automatic drive_frame(input bq_t d, input int stall_at);
        int  i = 0;
        int  budget = 0;
        bit  stalled = 1'b0;
        bit  acc;
        while (i < d.size() && budget < 5000) begin
            if (stall_at == i && !stalled) begin
                bus.i_valid = 1'b0;
                stalled = 1'b1;
            end else begin
                bus.i_valid = 1'b1;
                bus.iv_data = d[i];
                bus.i_sop   = (i == 0);
                bus.i_eop   = (i == d.size() - 1);
            end
            @(negedge clk);
            acc = bus.i_valid && bus.o_ready;
            @(posedge clk); #1;
            if (acc) i++;
            budget++;
        end
        bus.i_valid = 1'b0;
        bus.i_sop   = 1'b0;
        bus.i_eop   = 1'b0;
        checks++;
        if (i != d.size()) begin
            errors++;
            $display("FAIL drive_accept: accepted %0d of %0d bytes", i, d.size());
        end
    endtask

    task automatic wait_frames(input int n);
        int b = 0;
        while (frame_end.size() < n && b < 4000) begin
            @(negedge clk); #1;
            b++;
        end
        checks++;
        if (frame_end.size() < n) begin
            errors++;
            $display("FAIL wait_frames: got %0d frames, need %0d", frame_end.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (bus.o_gmii_tx_en !== 1'b0) begin errors++; $display("FAIL rst_tx_en: got %b want 0", bus.o_gmii_tx_en); end
        if (bus.o_gmii_tx_er !== 1'b0) begin errors++; $display("FAIL rst_tx_er: got %b want 0", bus.o_gmii_tx_er); end
        if (bus.ov_gmii_txd !== 8'h00) begin errors++; $display("FAIL rst_txd: got %h want 00", bus.ov_gmii_txd); end
        if (bus.o_underrun !== 1'b0)   begin errors++; $display("FAIL rst_underrun: got %b want 0", bus.o_underrun); end
        if (bus.o_ready !== 1'b0)      begin errors++; $display("FAIL rst_ready: got %b want 0", bus.o_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_idle_discard();
        bq_t d, e;
        clear_mon();
        bus.i_valid = 1'b1; bus.i_sop = 1'b0; bus.i_eop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.iv_data = 8'($urandom_range(0, 255));
            @(negedge clk);
            checks += 2;
            if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL idle_discard_ready: got %b want 1", bus.o_ready); end
            if (bus.o_gmii_tx_en !== 1'b0) begin errors++; $display("FAIL idle_discard_tx_en: got %b want 0", bus.o_gmii_tx_en); end
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        d = rand_bytes(70);
        e = build_expected(d);
        drive_frame(d, -1);
        wait_frames(1);
        checks++;
        if (count_diff(frame_bytes(0), e) != 0) begin
            errors++; $display("FAIL idle_discard_frame: %0d byte differences (len %0d want %0d)",
                               count_diff(frame_bytes(0), e), frame_bytes(0).size(), e.size());
        end
    endtask

    task automatic test_min_frame();
        bq_t d, e;
        clear_mon();
        d = {};
        for (int i = 0; i < 60; i++) d.push_back(8'(i));
        e = build_expected(d);
        drive_frame(d, -1);
        wait_frames(1);
        checks += 3;
        if (frame_bytes(0).size() != 72) begin errors++; $display("FAIL min_len: got %0d want 72", frame_bytes(0).size()); end
        if (count_diff(frame_bytes(0), e) != 0) begin errors++; $display("FAIL min_content: %0d byte differences, want 0", count_diff(frame_bytes(0), e)); end
        if (rdy_cnt != 60) begin errors++; $display("FAIL min_ready: got %0d ready cycles want 60", rdy_cnt); end
    endtask

    task automatic test_pad();
        bq_t d, e;
        clear_mon();
        d = {8'hAA};
        e = build_expected(d);
        drive_frame(d, -1);
        wait_frames(1);
        checks += 4;
        if (frame_bytes(0).size() != 72) begin errors++; $display("FAIL pad_len: got %0d want 72", frame_bytes(0).size()); end
        if (count_diff(frame_bytes(0), e) != 0) begin errors++; $display("FAIL pad_content: %0d byte differences, want 0", count_diff(frame_bytes(0), e)); end
        if (rdy_cnt != 1) begin errors++; $display("FAIL pad_ready: got %0d ready cycles want 1", rdy_cnt); end
        if (er_cnt != 0) begin errors++; $display("FAIL pad_tx_er: got %0d er cycles want 0", er_cnt); end
    endtask

    task automatic test_back_to_back();
        bq_t d0, d1, e0, e1;
        clear_mon();
        d0 = rand_bytes(64); d1 = rand_bytes(64);
        e0 = build_expected(d0); e1 = build_expected(d1);
        drive_frame(d0, -1);
        drive_frame(d1, -1);
        wait_frames(2);
        checks += 3;
        if (count_diff(frame_bytes(0), e0) != 0) begin errors++; $display("FAIL b2b_frame0: %0d byte differences, want 0", count_diff(frame_bytes(0), e0)); end
        if (count_diff(frame_bytes(1), e1) != 0) begin errors++; $display("FAIL b2b_frame1: %0d byte differences, want 0", count_diff(frame_bytes(1), e1)); end
        if (gaps.size() != 1 || gaps[0] != IFG) begin
            errors++; $display("FAIL b2b_gap: got %0d gaps first %0d want 1 gap of %0d", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1, IFG);
        end
    endtask

    task automatic test_random();
        bq_t d[6], e[6];
        clear_mon();
        for (int f = 0; f < 6; f++) begin
            d[f] = rand_bytes($urandom_range(1, 150));
            e[f] = build_expected(d[f]);
        end
        for (int f = 0; f < 6; f++) drive_frame(d[f], -1);
        wait_frames(6);
        for (int f = 0; f < 6; f++) begin
            checks++;
            if (count_diff(frame_bytes(f), e[f]) != 0) begin
                errors++; $display("FAIL rand_frame%0d: %0d byte differences (len %0d want %0d)",
                                   f, count_diff(frame_bytes(f), e[f]), frame_bytes(f).size(), e[f].size());
            end
        end
        foreach (gaps[g]) begin
            checks++;
            if (gaps[g] != IFG) begin errors++; $display("FAIL rand_gap%0d: got %0d want %0d", g, gaps[g], IFG); end
        end
    endtask

    task automatic test_underrun();
        bq_t d0, d1, e0, e1, got;
        clear_mon();
        d0 = rand_bytes(40); d1 = rand_bytes(30);
        e0 = build_expected(d0); e1 = build_expected(d1);
        drive_frame(d0, 20);
        drive_frame(d1, -1);
        wait_frames(2);
        got = frame_bytes(0);
        checks += 7;
        if (got.size() != 29) begin errors++; $display("FAIL urun_len: got %0d want 29", got.size()); end
        if (got.size() == 29 && count_diff(got[0:27], e0[0:27]) != 0) begin
            errors++; $display("FAIL urun_prefix: %0d byte differences, want 0", count_diff(got[0:27], e0[0:27]));
        end
        if (got.size() > 0 && got[got.size()-1] !== 8'h00) begin errors++; $display("FAIL urun_last: got %h want 00", got[got.size()-1]); end
        if (er_cnt != 1) begin errors++; $display("FAIL urun_tx_er: got %0d er cycles want 1", er_cnt); end
        if (un_cnt != 1) begin errors++; $display("FAIL urun_pulse: got %0d pulses want 1", un_cnt); end
        if (gaps.size() < 1 || gaps[0] != 20 + IFG) begin
            errors++; $display("FAIL urun_gap: got %0d want %0d", (gaps.size() > 0) ? gaps[0] : -1, 20 + IFG);
        end
        if (count_diff(frame_bytes(1), e1) != 0) begin errors++; $display("FAIL urun_next: %0d byte differences, want 0", count_diff(frame_bytes(1), e1)); end
    endtask

    task automatic test_reset_mid();
        bq_t d0, d1, e0, e1, got;
        int b = 0;
        clear_mon();
        d0 = rand_bytes(60); d1 = rand_bytes(80);
        e0 = build_expected(d0); e1 = build_expected(d1);
        drive_frame(d0, -1);
        while (cap.size() < 71 && b < 200) begin
            @(negedge clk); #1;
            b++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks += 6;
        if (bus.o_gmii_tx_en !== 1'b0) begin errors++; $display("FAIL rmid_tx_en: got %b want 0", bus.o_gmii_tx_en); end
        if (bus.o_gmii_tx_er !== 1'b0) begin errors++; $display("FAIL rmid_tx_er: got %b want 0", bus.o_gmii_tx_er); end
        if (bus.ov_gmii_txd !== 8'h00) begin errors++; $display("FAIL rmid_txd: got %h want 00", bus.ov_gmii_txd); end
        if (bus.o_ready !== 1'b0)      begin errors++; $display("FAIL rmid_ready: got %b want 0", bus.o_ready); end
        #1;
        got = frame_bytes(0);
        if (got.size() != 71) begin errors++; $display("FAIL rmid_len: got %0d want 71", got.size()); end
        if (got.size() == 71 && count_diff(got, e0[0:70]) != 0) begin
            errors++; $display("FAIL rmid_prefix: %0d byte differences, want 0", count_diff(got, e0[0:70]));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive_frame(d1, -1);
        wait_frames(2);
        checks++;
        if (count_diff(frame_bytes(1), e1) != 0) begin errors++; $display("FAIL rmid_next: %0d byte differences, want 0", count_diff(frame_bytes(1), e1)); end
    endtask

    task automatic test_long();
        bq_t d, e;
        clear_mon();
        d = rand_bytes(1514);
        e = build_expected(d);
        drive_frame(d, -1);
        wait_frames(1);
        checks += 2;
        if (frame_bytes(0).size() != 1526) begin errors++; $display("FAIL long_len: got %0d want 1526", frame_bytes(0).size()); end
        if (count_diff(frame_bytes(0), e) != 0) begin errors++; $display("FAIL long_content: %0d byte differences, want 0", count_diff(frame_bytes(0), e)); end
    endtask

    initial begin
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tab[n] = c;
        end
        bus.i_valid = 1'b0; bus.i_sop = 1'b0; bus.i_eop = 1'b0; bus.iv_data = '0;
        prev_en = 1'b0; seen_fall = 1'b0;
        er_cnt = 0; un_cnt = 0; rdy_cnt = 0; low_run = 0;
        test_reset();
        test_idle_discard();
        test_min_frame();
        test_pad();
        test_back_to_back();
        test_random();
        test_underrun();
        test_reset_mid();
        test_long();
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
